// File: rtl/myo_pkg.sv
// Shared definitions for the myoelectric SPI frame scheduler: state encoding,
// datapath widths and a saturating-increment helper.
package myo_pkg;

  localparam int MOTOR_W = 8;
  localparam int CNT_W   = 32;
  localparam int STAT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_START       = 3'd1,
    ST_WAIT_DONE   = 3'd2,
    ST_NEXT        = 3'd3,
    ST_WAIT_PERIOD = 3'd4
  } sched_state_e;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/myo_frame_scheduler_mask_next.sv
// Combinational search for the lowest set mask bit above the current index,
// or the lowest set bit overall when from_zero_i is high.
module myo_mask_next
  import myo_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 6
) (
  input  logic [NUMBER_OF_MOTORS-1:0] mask_i,
  input  logic [MOTOR_W-1:0]          cur_i,
  input  logic                        from_zero_i,
  output logic [MOTOR_W-1:0]          idx_o,
  output logic                        found_o
);

  logic hit_s;

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    hit_s   = 1'b0;
    for (int j = NUMBER_OF_MOTORS - 1; j >= 0; j--) begin
      hit_s   = mask_i[j] & (from_zero_i | (MOTOR_W'(j) > cur_i));
      idx_o   = hit_s ? MOTOR_W'(j) : idx_o;
      found_o = found_o | hit_s;
    end
  end

endmodule

// File: rtl/myo_frame_scheduler.sv
// Sequences SPI frames across the enabled motors of one bus, paces sweeps to a
// programmable period, and reports latch/PID/timeout/overrun events.
module myo_frame_scheduler
  import myo_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int TIMEOUT_CYCLES   = 2000
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable_i,
  input  logic [NUMBER_OF_MOTORS-1:0] motor_mask_i,
  input  logic [CNT_W-1:0]            period_cycles_i,
  input  logic                        clear_stats_i,
  input  logic                        spi_done_i,
  input  logic                        ss_n_i,
  output logic                        start_o,
  output logic [MOTOR_W-1:0]          motor_o,
  output logic [NUMBER_OF_MOTORS-1:0] ss_n_o,
  output logic                        latch_o,
  output logic                        pid_update_o,
  output logic [MOTOR_W-1:0]          pid_motor_o,
  output logic                        timeout_o,
  output logic                        sweep_done_o,
  output logic [CNT_W-1:0]            sweep_cycles_o,
  output logic                        overrun_o,
  output logic [STAT_W-1:0]           timeout_count_o
);

  sched_state_e       state_q, state_d;
  logic [MOTOR_W-1:0] motor_q, motor_d, pid_motor_q, pid_motor_d;
  logic               pid_update_q, pid_update_d, done_prev_q;
  logic [CNT_W-1:0]   frame_timer_q, frame_timer_d;
  logic [CNT_W-1:0]   sweep_cnt_q, sweep_cnt_d, sweep_cycles_q, sweep_cycles_d;
  logic [STAT_W-1:0]  timeout_count_q, timeout_count_d;

  logic               done_rise_s, frame_expired_s, mask_any_s, period_reached_s, restart_s;
  logic [MOTOR_W-1:0] next_idx_s, first_idx_s;
  logic               next_found_s, first_found_s;

  assign done_rise_s      = spi_done_i & ~done_prev_q;
  assign frame_expired_s  = (frame_timer_q >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign mask_any_s       = |motor_mask_i;
  assign period_reached_s = (period_cycles_i == 32'd0) || (sweep_cnt_q >= period_cycles_i - 32'd1);

  myo_mask_next #(.NUMBER_OF_MOTORS(NUMBER_OF_MOTORS)) u_next (
    .mask_i(motor_mask_i), .cur_i(motor_q), .from_zero_i(1'b0),
    .idx_o(next_idx_s), .found_o(next_found_s)
  );

  myo_mask_next #(.NUMBER_OF_MOTORS(NUMBER_OF_MOTORS)) u_first (
    .mask_i(motor_mask_i), .cur_i(motor_q), .from_zero_i(1'b1),
    .idx_o(first_idx_s), .found_o(first_found_s)
  );

  // Scheduler next-state, pulse outputs and counter updates.
  always_comb begin
    state_d       = state_q;
    motor_d       = motor_q;
    frame_timer_d = frame_timer_q;
    restart_s     = 1'b0;
    start_o       = 1'b0;
    latch_o       = 1'b0;
    timeout_o     = 1'b0;
    sweep_done_o  = 1'b0;
    overrun_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && mask_any_s && first_found_s) begin
          motor_d = first_idx_s;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        start_o       = 1'b1;
        frame_timer_d = '0;
        state_d       = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        frame_timer_d = frame_timer_q + 32'd1;
        // A done edge in the expiry cycle still counts as a completed frame.
        if (done_rise_s) begin
          latch_o = 1'b1;
          state_d = ST_NEXT;
        end else if (frame_expired_s) begin
          timeout_o = 1'b1;
          state_d   = ST_NEXT;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_NEXT: begin
        sweep_done_o = ~next_found_s;
        if (!enable_i || !mask_any_s) begin
          state_d = ST_IDLE;
        end else if (next_found_s) begin
          motor_d = next_idx_s;
          state_d = ST_START;
        end else if (period_reached_s) begin
          overrun_o = (period_cycles_i != 32'd0) && (sweep_cnt_q >= period_cycles_i);
          restart_s = 1'b1;
          motor_d   = first_idx_s;
          state_d   = ST_START;
        end else begin
          state_d = ST_WAIT_PERIOD;
        end
      end
      ST_WAIT_PERIOD: begin
        if (!enable_i || !mask_any_s) begin
          state_d = ST_IDLE;
        end else if (period_reached_s) begin
          restart_s = 1'b1;
          motor_d   = first_idx_s;
          state_d   = ST_START;
        end else begin
          state_d = ST_WAIT_PERIOD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sweep_cnt_d     = (state_q == ST_IDLE || restart_s) ? '0 : sat_inc_cnt(sweep_cnt_q);
    sweep_cycles_d  = restart_s ? sat_inc_cnt(sweep_cnt_q) : sweep_cycles_q;
    pid_update_d    = latch_o;
    pid_motor_d     = latch_o ? motor_q : pid_motor_q;
    timeout_count_d = clear_stats_i ? '0 :
                      (timeout_o && !(&timeout_count_q)) ? timeout_count_q + 16'd1 :
                      timeout_count_q;
  end

  // State and datapath registers; the done history resets high so a level
  // held across reset is not mistaken for a fresh edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      motor_q         <= '0;
      pid_motor_q     <= '0;
      pid_update_q    <= 1'b0;
      done_prev_q     <= 1'b1;
      frame_timer_q   <= '0;
      sweep_cnt_q     <= '0;
      sweep_cycles_q  <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      motor_q         <= motor_d;
      pid_motor_q     <= pid_motor_d;
      pid_update_q    <= pid_update_d;
      done_prev_q     <= spi_done_i;
      frame_timer_q   <= frame_timer_d;
      sweep_cnt_q     <= sweep_cnt_d;
      sweep_cycles_q  <= sweep_cycles_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  // Route the master's slave select to the active motor only.
  always_comb begin
    ss_n_o = '1;
    for (int j = 0; j < NUMBER_OF_MOTORS; j++) begin
      ss_n_o[j] = (state_q != ST_IDLE && motor_q == MOTOR_W'(j)) ? ss_n_i : 1'b1;
    end
  end

  assign motor_o         = motor_q;
  assign pid_update_o    = pid_update_q;
  assign pid_motor_o     = pid_motor_q;
  assign sweep_cycles_o  = sweep_cycles_q;
  assign timeout_count_o = timeout_count_q;

endmodule

// File: tb/tb_myo_frame_scheduler.sv
// Directed bench for myo_frame_scheduler: free-run sweeps, sparse masks,
// timeouts, enable drop, period pacing/overrun and reset behaviour.
module tb_myo_frame_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable_i;
  logic [5:0]  motor_mask_i;
  logic [31:0] period_cycles_i;
  logic        clear_stats_i;
  logic        spi_done_i;
  logic        ss_n_i;
  logic        start_o, latch_o, pid_update_o, timeout_o, sweep_done_o, overrun_o;
  logic [7:0]  motor_o, pid_motor_o;
  logic [5:0]  ss_n_o;
  logic [31:0] sweep_cycles_o;
  logic [15:0] timeout_count_o;

  int vectors = 0;
  int miscompares = 0;

  myo_frame_scheduler #(.NUMBER_OF_MOTORS(6), .TIMEOUT_CYCLES(2000)) dut (
    .clock(clock), .reset_n(reset_n), .enable_i(enable_i), .motor_mask_i(motor_mask_i),
    .period_cycles_i(period_cycles_i), .clear_stats_i(clear_stats_i), .spi_done_i(spi_done_i),
    .ss_n_i(ss_n_i), .start_o(start_o), .motor_o(motor_o), .ss_n_o(ss_n_o), .latch_o(latch_o),
    .pid_update_o(pid_update_o), .pid_motor_o(pid_motor_o), .timeout_o(timeout_o),
    .sweep_done_o(sweep_done_o), .sweep_cycles_o(sweep_cycles_o), .overrun_o(overrun_o),
    .timeout_count_o(timeout_count_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      seen = start_o;
    end
    chk("start_seen", {31'd0, seen}, 32'd1);
  endtask

  // One frame: start seen at negedge n0, done rises at negedge n0+len.
  task automatic do_frame(input int m, input int len, input logic last, input logic ovr,
                          input int exp_sc);
    logic [5:0] e_ss;
    wait_start(6000);
    e_ss    = 6'h3F;
    e_ss[m] = 1'b0;
    chk("motor", motor_o, m);
    chk("ss_n_active", {26'd0, ss_n_o}, {26'd0, e_ss});
    if (exp_sc >= 0) chk("sweep_cycles", sweep_cycles_o, exp_sc);
    @(negedge clock);
    chk("early_latch", {31'd0, latch_o}, 32'd0);
    spi_done_i = 1'b0;
    repeat (len - 1) @(negedge clock);
    spi_done_i = 1'b1;
    #1;
    chk("latch", {31'd0, latch_o}, 32'd1);
    chk("no_timeout_on_latch", {31'd0, timeout_o}, 32'd0);
    @(negedge clock);
    chk("pid_update", {31'd0, pid_update_o}, 32'd1);
    chk("pid_motor", pid_motor_o, m);
    chk("latch_single", {31'd0, latch_o}, 32'd0);
    chk("sweep_done", {31'd0, sweep_done_o}, {31'd0, last});
    chk("overrun", {31'd0, overrun_o}, {31'd0, ovr});
    spi_done_i = 1'b0;
  endtask

  task automatic do_timeout(input int m, input logic clr, input int exp_cnt);
    wait_start(6000);
    chk("to_motor", motor_o, m);
    repeat (1999) @(negedge clock);
    chk("timeout_early", {31'd0, timeout_o}, 32'd0);
    @(negedge clock);
    chk("timeout", {31'd0, timeout_o}, 32'd1);
    chk("to_no_latch", {31'd0, latch_o}, 32'd0);
    clear_stats_i = clr;
    @(negedge clock);
    clear_stats_i = 1'b0;
    chk("to_no_pid", {31'd0, pid_update_o}, 32'd0);
    chk("timeout_count", {16'd0, timeout_count_o}, exp_cnt);
  endtask

  initial begin
    reset_n = 1'b0; enable_i = 1'b1; motor_mask_i = 6'h3F; period_cycles_i = 32'd0;
    clear_stats_i = 1'b0; spi_done_i = 1'b1; ss_n_i = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_motor", motor_o, 32'd0);
    chk("rst_start", {31'd0, start_o}, 32'd0);
    chk("rst_pid", {31'd0, pid_update_o}, 32'd0);
    chk("rst_pid_motor", pid_motor_o, 32'd0);
    chk("rst_sweep_cycles", sweep_cycles_o, 32'd0);
    chk("rst_timeout_count", {16'd0, timeout_count_o}, 32'd0);
    chk("rst_ss_n", {26'd0, ss_n_o}, 32'h3F);
    reset_n = 1'b1;

    // Free-run, all motors, done 40 cycles after start; done held high out of reset.
    for (int k = 0; k < 6; k++) do_frame(k, 40, k == 5, 1'b0, -1);
    for (int k = 0; k < 6; k++) do_frame(k, 40, k == 5, 1'b0, (k == 0) ? 252 : -1);

    // Sparse mask, applied while the scheduler sits in NEXT.
    motor_mask_i = 6'b100101;
    do_frame(0, 40, 1'b0, 1'b0, 252);
    do_frame(2, 40, 1'b0, 1'b0, -1);
    do_frame(5, 40, 1'b1, 1'b0, -1);

    // Timeout on motor 3, then done coincident with expiry on motor 5.
    motor_mask_i = 6'h3F;
    do_frame(0, 10, 1'b0, 1'b0, 126);
    do_frame(1, 10, 1'b0, 1'b0, -1);
    do_frame(2, 10, 1'b0, 1'b0, -1);
    do_timeout(3, 1'b0, 1);
    do_frame(4, 10, 1'b0, 1'b0, -1);
    do_frame(5, 2000, 1'b1, 1'b0, -1);
    chk("count_after_coincident", {16'd0, timeout_count_o}, 32'd1);
    do_timeout(0, 1'b1, 0);

    // enable_i drops mid-frame on motor 1.
    wait_start(6000);
    chk("en_motor", motor_o, 32'd1);
    repeat (10) @(negedge clock);
    enable_i = 1'b0;
    repeat (30) @(negedge clock);
    spi_done_i = 1'b1;
    #1;
    chk("en_latch", {31'd0, latch_o}, 32'd1);
    @(negedge clock);
    chk("en_pid", {31'd0, pid_update_o}, 32'd1);
    spi_done_i = 1'b0;
    @(negedge clock);
    chk("idle_ss_n", {26'd0, ss_n_o}, 32'h3F);
    repeat (5) @(negedge clock);
    chk("idle_no_start", {31'd0, start_o}, 32'd0);

    // Paced sweeps: period 5000 fits, period 300 overruns.
    period_cycles_i = 32'd5000;
    enable_i = 1'b1;
    for (int k = 0; k < 6; k++) do_frame(k, 98, k == 5, 1'b0, -1);
    do_frame(0, 98, 1'b0, 1'b0, 5000);
    period_cycles_i = 32'd300;
    for (int k = 1; k < 6; k++) do_frame(k, 98, k == 5, k == 5, -1);
    do_frame(0, 98, 1'b0, 1'b0, 600);

    // Reset in the middle of a frame.
    wait_start(6000);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_motor", motor_o, 32'd0);
    chk("midrst_ss_n", {26'd0, ss_n_o}, 32'h3F);
    chk("midrst_sweep_cycles", sweep_cycles_o, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
